// File: rtl/fir_sym_param.sv
// Parametrised symmetric-coefficient FIR with runtime-loadable coefficients.
// Four-stage valid-qualified, stallable pipeline: pre-add, multiply, sum, scale/saturate.
module fir_sym_param #(
  parameter int TAPS  = 27,
  parameter int DW    = 4,
  parameter int CW    = 9,
  parameter int OW    = 16,
  parameter int SHIFT = 0,
  parameter int SAT   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en_n,
  input  logic                          clr,
  input  logic                          i_vld,
  input  logic signed [DW-1:0]          i_data,
  input  logic                          cfg_we,
  input  logic [$clog2((TAPS+1)/2)-1:0] cfg_addr,
  input  logic signed [CW-1:0]          cfg_data,
  output logic                          o_vld,
  output logic signed [OW-1:0]          o_data,
  output logic                          o_sat
);
  localparam int NH = (TAPS + 1) / 2;
  localparam int CA = $clog2(NH);
  localparam int PW = DW + 1;
  localparam int MW = PW + CW;
  localparam int AW = MW + CA;
  localparam int EW = AW + OW + 1;
  localparam int HS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [CA:0] NHV = (CA+1)'(NH);
  localparam logic signed [EW-1:0] HALF =
    (SHIFT > 0) ? ({{(EW-1){1'b0}}, 1'b1} << HS) : '0;
  localparam logic signed [EW-1:0] MAXV = {{(EW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [EW-1:0] MINV = {{(EW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  logic signed [CW-1:0] r_coef [NH];
  logic signed [DW-1:0] r_x    [TAPS];
  logic signed [PW-1:0] r_p    [NH];
  logic signed [PW-1:0] w_pre  [NH];
  logic signed [MW-1:0] r_m    [NH];
  logic signed [MW-1:0] w_prod [NH];
  logic signed [AW-1:0] r_acc;
  logic signed [AW-1:0] w_sum;
  logic signed [EW-1:0] w_round;
  logic signed [EW-1:0] w_scaled;
  logic signed [OW-1:0] w_out;
  logic                 w_clamp;
  logic                 r_xVld;
  logic                 r_pVld;
  logic                 r_mVld;
  logic                 r_accVld;

  // Coefficient writes ignore stall and clear; only reset wipes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NH; k++) r_coef[k] <= '0;
    end else if (cfg_we && ({1'b0, cfg_addr} < NHV)) begin
      r_coef[cfg_addr] <= cfg_data;
    end
  end

  always_comb begin
    for (int k = 0; k < NH - 1; k++) begin
      w_pre[k] = PW'(r_x[k]) + PW'(r_x[TAPS-1-k]);
    end
    w_pre[NH-1] = PW'(r_x[NH-1]);
    for (int k = 0; k < NH; k++) begin
      w_prod[k] = MW'(r_p[k]) * MW'(r_coef[k]);
    end
    w_sum = '0;
    for (int k = 0; k < NH; k++) begin
      w_sum = w_sum + AW'(r_m[k]);
    end
  end

  // Round half-up then either clamp to the output range or wrap to OW bits.
  always_comb begin
    w_round  = EW'(r_acc) + HALF;
    w_scaled = w_round >>> SHIFT;
    w_out    = w_scaled[OW-1:0];
    w_clamp  = 1'b0;
    if (SAT != 0) begin
      if (w_scaled > MAXV) begin
        w_out   = MAXV[OW-1:0];
        w_clamp = 1'b1;
      end else if (w_scaled < MINV) begin
        w_out   = MINV[OW-1:0];
        w_clamp = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) r_x[k] <= '0;
      for (int k = 0; k < NH; k++) begin
        r_p[k] <= '0;
        r_m[k] <= '0;
      end
      r_acc    <= '0;
      r_xVld   <= 1'b0;
      r_pVld   <= 1'b0;
      r_mVld   <= 1'b0;
      r_accVld <= 1'b0;
      o_vld    <= 1'b0;
      o_data   <= '0;
      o_sat    <= 1'b0;
    end else if (clr) begin
      for (int k = 0; k < TAPS; k++) r_x[k] <= '0;
      for (int k = 0; k < NH; k++) begin
        r_p[k] <= '0;
        r_m[k] <= '0;
      end
      r_acc    <= '0;
      r_xVld   <= 1'b0;
      r_pVld   <= 1'b0;
      r_mVld   <= 1'b0;
      r_accVld <= 1'b0;
      o_vld    <= 1'b0;
      o_data   <= '0;
      o_sat    <= 1'b0;
    end else if (!en_n) begin
      if (i_vld) begin
        r_x[0] <= i_data;
        for (int k = 1; k < TAPS; k++) r_x[k] <= r_x[k-1];
      end
      r_xVld   <= i_vld;
      r_pVld   <= r_xVld;
      r_mVld   <= r_pVld;
      r_accVld <= r_mVld;
      o_vld    <= r_accVld;
      if (r_xVld) r_p <= w_pre;
      if (r_pVld) r_m <= w_prod;
      if (r_mVld) r_acc <= w_sum;
      if (r_accVld) begin
        o_data <= w_out;
        o_sat  <= w_clamp;
      end
    end else begin
      o_vld <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fir_sym_param.sv
// Bench for fir_sym_param: four parameterisations share one stimulus stream and
// are scored against a direct-convolution reference model through a queue.
module tb_fir_sym_param;
  localparam int TAPS = 27;
  localparam int NH   = 14;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en_n;
  logic              clr;
  logic              i_vld;
  logic signed [3:0] i_data;
  logic              cfg_we;
  logic [3:0]        cfg_addr;
  logic signed [8:0] cfg_data;

  logic               oVld [4];
  logic               oSat [4];
  logic signed [15:0] oData0;
  logic signed [11:0] oData1;
  logic signed [11:0] oData2;
  logic signed [15:0] oData3;

  int     nChecks = 0;
  int     nFails  = 0;
  int     coefM [NH];
  int     hist [TAPS];
  longint sbQ [$];
  logic   lastEnN = 1'b0;
  int     planCoef [NH] = '{1, 4, 0, 6, 1, 8, 4, 9, 10, 11, 23, 12, 79, 140};

  always #5 clk = ~clk;

  fir_sym_param u0 (.clk(clk), .rst_n(rst_n), .en_n(en_n), .clr(clr), .i_vld(i_vld),
    .i_data(i_data), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .o_vld(oVld[0]), .o_data(oData0), .o_sat(oSat[0]));
  fir_sym_param #(.OW(12), .SAT(1)) u1 (.clk(clk), .rst_n(rst_n), .en_n(en_n), .clr(clr),
    .i_vld(i_vld), .i_data(i_data), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .o_vld(oVld[1]), .o_data(oData1), .o_sat(oSat[1]));
  fir_sym_param #(.OW(12), .SAT(0)) u2 (.clk(clk), .rst_n(rst_n), .en_n(en_n), .clr(clr),
    .i_vld(i_vld), .i_data(i_data), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .o_vld(oVld[2]), .o_data(oData2), .o_sat(oSat[2]));
  fir_sym_param #(.SHIFT(2)) u3 (.clk(clk), .rst_n(rst_n), .en_n(en_n), .clr(clr),
    .i_vld(i_vld), .i_data(i_data), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .o_vld(oVld[3]), .o_data(oData3), .o_sat(oSat[3]));

  task automatic checkOutput(input string name, input longint act, input longint exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scaling of an exact filter sum into one output format.
  function automatic longint scaleRef(input longint y, input int sh, input int ow,
                                      input bit sat, output bit clamped);
    longint r;
    longint hi;
    longint lo;
    r = y;
    if (sh > 0) r = (y + (longint'(1) <<< (sh - 1))) >>> sh;
    hi = (longint'(1) <<< (ow - 1)) - 1;
    lo = -(longint'(1) <<< (ow - 1));
    clamped = 1'b0;
    if (sat) begin
      if (r > hi) begin
        r = hi;
        clamped = 1'b1;
      end else if (r < lo) begin
        r = lo;
        clamped = 1'b1;
      end
    end else begin
      r = (r <<< (64 - ow)) >>> (64 - ow);
    end
    return r;
  endfunction

  function automatic void flushModel();
    sbQ.delete();
    for (int k = 0; k < TAPS; k++) hist[k] = 0;
  endfunction

  function automatic void modelAccept(input int data);
    longint y;
    int     idx;
    for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = data;
    y = 0;
    for (int k = 0; k < TAPS; k++) begin
      idx = (k < NH) ? k : TAPS - 1 - k;
      y += longint'(coefM[idx]) * longint'(hist[k]);
    end
    sbQ.push_back(y);
  endfunction

  // One clock of stimulus; returns 1 time unit after the edge.
  task automatic applyStimulus(input bit vld, input int data, input bit enN, input bit clrIn,
                               input bit we, input int addr, input int cdata);
    i_vld    = vld;
    i_data   = data[3:0];
    en_n     = enN;
    clr      = clrIn;
    cfg_we   = we;
    cfg_addr = addr[3:0];
    cfg_data = cdata[8:0];
    if (vld && !enN && !clrIn) modelAccept(data);
    @(posedge clk);
    #1;
    if (clrIn) flushModel();
    if (we && addr < NH) coefM[addr] = cdata;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic loadCoefs(input bit randomCoefs);
    int c;
    for (int k = 0; k < NH; k++) begin
      c = randomCoefs ? int'($urandom_range(511)) - 256 : planCoef[k];
      applyStimulus(0, 0, 0, 0, 1, k, c);
    end
  endtask

  always @(posedge clk) lastEnN <= en_n;

  // Monitor: every presented output is matched against the oldest expectation.
  initial begin
    longint y;
    longint e;
    bit     s;
    forever begin
      @(negedge clk);
      if (lastEnN) checkOutput("stall_no_vld", oVld[0] | oVld[1] | oVld[2] | oVld[3], 0);
      if (oVld[0]) begin
        checkOutput("sb_has_entry", sbQ.size() > 0, 1);
        for (int k = 1; k < 4; k++) checkOutput("vld_together", oVld[k], 1);
        if (sbQ.size() > 0) begin
          y = sbQ.pop_front();
          e = scaleRef(y, 0, 16, 1'b1, s);
          checkOutput("u0_data", oData0, e);
          checkOutput("u0_sat", oSat[0], s);
          e = scaleRef(y, 0, 12, 1'b1, s);
          checkOutput("u1_data", oData1, e);
          checkOutput("u1_sat", oSat[1], s);
          e = scaleRef(y, 0, 12, 1'b0, s);
          checkOutput("u2_data", oData2, e);
          checkOutput("u2_sat", oSat[2], s);
          e = scaleRef(y, 2, 16, 1'b1, s);
          checkOutput("u3_data", oData3, e);
          checkOutput("u3_sat", oSat[3], s);
        end
      end
    end
  end

  initial begin
    int v;
    int st;
    int cl;
    int d;
    for (int k = 0; k < NH; k++) coefM[k] = 0;
    flushModel();
    rst_n = 1'b0;
    i_vld = 0; i_data = 0; en_n = 0; clr = 0; cfg_we = 0; cfg_addr = 0; cfg_data = 0;
    #12;
    checkOutput("rst_vld0", oVld[0], 0);
    checkOutput("rst_vld1", oVld[1], 0);
    checkOutput("rst_vld2", oVld[2], 0);
    checkOutput("rst_vld3", oVld[3], 0);
    checkOutput("rst_data0", oData0, 0);
    checkOutput("rst_data1", oData1, 0);
    checkOutput("rst_data2", oData2, 0);
    checkOutput("rst_data3", oData3, 0);
    checkOutput("rst_sat0", oSat[0], 0);
    checkOutput("rst_sat1", oSat[1], 0);
    checkOutput("rst_sat2", oSat[2], 0);
    checkOutput("rst_sat3", oSat[3], 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] impulse with plan coefficients");
    loadCoefs(0);
    applyStimulus(0, 0, 0, 0, 1, 14, 77);
    applyStimulus(0, 0, 0, 0, 1, 15, -50);
    idle(3);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      checkOutput("latency_vld", oVld[0], (k == 4) ? 1 : 0);
    end
    for (int i = 0; i < 30; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0);
    idle(6);

    $display("[TB] positive step");
    for (int i = 0; i < 40; i++) applyStimulus(1, 7, 0, 0, 0, 0, 0);
    checkOutput("step_u0", oData0, 3332);
    checkOutput("step_u1_clamp", oData1, 2047);
    checkOutput("step_u2_wrap", oData2, -764);
    checkOutput("step_u3_round", oData3, 833);

    $display("[TB] negative step with stall");
    for (int i = 0; i < 15; i++) applyStimulus(1, -8, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, -8, 1, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++) applyStimulus(1, -8, 0, 0, 0, 0, 0);
    checkOutput("neg_u1_data", oData1, -2048);
    checkOutput("neg_u1_sat", oSat[1], 1);
    checkOutput("neg_u2_data", oData2, 288);
    checkOutput("neg_u2_sat", oSat[2], 0);

    $display("[TB] clear mid-stream with coefficient write");
    for (int i = 0; i < 10; i++) applyStimulus(1, 5, 0, 0, 0, 0, 0);
    applyStimulus(1, 3, 0, 1, 1, 12, 100);
    checkOutput("clr_vld", oVld[0], 0);
    checkOutput("clr_data0", oData0, 0);
    checkOutput("clr_sat1", oSat[1], 0);
    checkOutput("clr_data2", oData2, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0);
    idle(6);

    $display("[TB] randomized traffic");
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 300; i++) begin
        v  = ($urandom_range(3) != 0) ? 1 : 0;
        st = ($urandom_range(9) == 0) ? 1 : 0;
        cl = ($urandom_range(59) == 0) ? 1 : 0;
        d  = int'($urandom_range(15)) - 8;
        applyStimulus(v[0], d, st[0], cl[0], 0, 0, 0);
      end
      idle(6);
      loadCoefs(1);
    end

    $display("[TB] asynchronous reset mid-stream");
    for (int i = 0; i < 12; i++) applyStimulus(1, int'($urandom_range(15)) - 8, 0, 0, 0, 0, 0);
    i_vld = 0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_vld", oVld[0], 0);
    checkOutput("arst_data0", oData0, 0);
    checkOutput("arst_data3", oData3, 0);
    checkOutput("arst_sat1", oSat[1], 0);
    flushModel();
    for (int k = 0; k < NH; k++) coefM[k] = 0;
    #1 rst_n = 1'b1;
    applyStimulus(1, 7, 0, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0);
    idle(4);
    loadCoefs(0);
    idle(2);
    applyStimulus(1, -8, 0, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0);

    idle(10);
    checkOutput("sb_drained", sbQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
